// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED PWM array.
//   Register address map, MODE bit positions, reset value of MODE and the
//   per-LED output mode encoding used in the LEDOUT registers.
package led_pkg;

  localparam logic [4:0] ADDR_MODE    = 5'h00;
  localparam logic [4:0] ADDR_GRPPWM  = 5'h01;
  localparam logic [4:0] ADDR_GRPFREQ = 5'h02;
  localparam logic [4:0] ADDR_LEDOUT0 = 5'h04;
  localparam logic [4:0] ADDR_PWM0    = 5'h10;

  localparam int MODE_SLEEP_BIT  = 4;
  localparam int MODE_DMBLNK_BIT = 5;

  localparam logic [7:0] MODE_RESET = 8'h10;

  // Two bits per LED inside LEDOUTn.
  typedef enum logic [1:0] {
    OFF     = 2'b00,
    ON      = 2'b01,
    PWM     = 2'b10,
    PWM_GRP = 2'b11
  } ledout_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED output.
//   Holds the shadow duty (reloaded only at the PWM period boundary), compares
//   it against the shared PWM counter and selects the LED drive from the
//   LEDOUT mode. The LED pin is driven from a register.
// Ports:
//   clk_400K  clock, rising edge
//   reset     asynchronous active-low reset
//   hold      sleep: clears the shadow duty and forces the LED off
//   wrap      high in the cycle the PWM counter rolls over to 0
//   duty      programmed duty (PWMi register, upper PWM_BITS bits)
//   pwm_cnt   shared free-running PWM counter
//   mode      LEDOUT field for this LED
//   grp_gate  group dim/blink gate
//   led       registered LED drive, 1 = on
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_400K,
  input  logic                reset,
  input  logic                hold,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  ledout_mode_e        mode,
  input  logic                grp_gate,
  output logic                led
);

  logic [PWM_BITS-1:0] shadow_duty;
  logic                raw_p0;
  logic                led_p0;

  // Shadow reload only on wrap, so a write never reshapes a running pulse.
  always_ff @(posedge clk_400K or negedge reset) begin
    if (!reset) begin
      shadow_duty <= '0;
    end else if (hold) begin
      shadow_duty <= '0;
    end else if (wrap) begin
      shadow_duty <= duty;
    end
  end

  // Stage p0: compare and mode select
  assign raw_p0 = (pwm_cnt < shadow_duty);

  always_comb begin
    led_p0 = 1'b0;
    case (mode)
      OFF:     led_p0 = 1'b0;
      ON:      led_p0 = 1'b1;
      PWM:     led_p0 = raw_p0;
      PWM_GRP: led_p0 = raw_p0 & grp_gate;
      default: led_p0 = 1'b0;
    endcase
  end

  // Stage p1: output register
  always_ff @(posedge clk_400K or negedge reset) begin
    if (!reset) begin
      led <= 1'b0;
    end else begin
      led <= hold ? 1'b0 : led_p0;
    end
  end

endmodule

// File: rtl/led_pwm_array.sv
// led_pwm_array: register-programmed PWM driver for NUM_LEDS LEDs.
//   Register file (MODE, GRPPWM, GRPFREQ, LEDOUT0..3, PWM0..15), the shared
//   PWM counter, the group dim counter, the blink prescaler/position and the
//   group gate. One led_pwm_channel per LED does the per-LED work.
// Ports:
//   clk_400K    clock, rising edge
//   reset       asynchronous active-low reset
//   reg_addr    register address
//   reg_wdata   write data
//   reg_write   write strobe (one cycle)
//   reg_read    read strobe (one cycle)
//   reg_rdata   read data, valid with reg_rvalid, held until the next read
//   reg_rvalid  one-cycle pulse, one cycle after reg_read
//   leds        registered LED drive, 1 = on
//   sleep       mirror of MODE.SLEEP
module led_pwm_array
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = 4,
  parameter int PWM_BITS       = 8,
  parameter int BLINK_PRESCALE = 400
) (
  input  logic                clk_400K,
  input  logic                reset,
  input  logic [4:0]          reg_addr,
  input  logic [7:0]          reg_wdata,
  input  logic                reg_write,
  input  logic                reg_read,
  output logic [7:0]          reg_rdata,
  output logic                reg_rvalid,
  output logic [NUM_LEDS-1:0] leds,
  output logic                sleep
);

  localparam int             PS_W    = (BLINK_PRESCALE > 1) ? $clog2(BLINK_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(BLINK_PRESCALE - 1);

  logic               mode_sleep;
  logic               mode_dmblnk;
  logic [7:0]         grppwm;
  logic [7:0]         grpfreq;
  ledout_mode_e       led_mode [NUM_LEDS];
  logic [7:0]         pwm_reg  [NUM_LEDS];

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [7:0]          grp_cnt;
  logic [7:0]          blink_pos;
  logic [7:0]          freq_cnt;
  logic [PS_W-1:0]     presc;

  logic [7:0] rd_data_p0;
  logic       wrap_p0;
  logic       tick_p0;
  logic       dmblnk_flip_p0;
  logic       grp_gate_p0;

  // Register file
  always_ff @(posedge clk_400K or negedge reset) begin
    if (!reset) begin
      mode_sleep  <= MODE_RESET[MODE_SLEEP_BIT];
      mode_dmblnk <= MODE_RESET[MODE_DMBLNK_BIT];
      grppwm      <= '0;
      grpfreq     <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_mode[i] <= OFF;
        pwm_reg[i]  <= '0;
      end
    end else if (reg_write) begin
      if (reg_addr == ADDR_MODE) begin
        mode_sleep  <= reg_wdata[MODE_SLEEP_BIT];
        mode_dmblnk <= reg_wdata[MODE_DMBLNK_BIT];
      end
      if (reg_addr == ADDR_GRPPWM)  grppwm  <= reg_wdata;
      if (reg_addr == ADDR_GRPFREQ) grpfreq <= reg_wdata;
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (reg_addr == ADDR_LEDOUT0 + 5'(i / 4))
          led_mode[i] <= ledout_mode_e'(reg_wdata[2*(i%4) +: 2]);
        if (reg_addr == ADDR_PWM0 + 5'(i))
          pwm_reg[i] <= reg_wdata;
      end
    end
  end

  // Read mux: fields belonging to absent LEDs and unmapped addresses stay 0.
  always_comb begin
    rd_data_p0 = '0;
    case (reg_addr)
      ADDR_MODE: begin
        rd_data_p0[MODE_SLEEP_BIT]  = mode_sleep;
        rd_data_p0[MODE_DMBLNK_BIT] = mode_dmblnk;
      end
      ADDR_GRPPWM:  rd_data_p0 = grppwm;
      ADDR_GRPFREQ: rd_data_p0 = grpfreq;
      default:      ;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (reg_addr == ADDR_LEDOUT0 + 5'(i / 4))
        rd_data_p0[2*(i%4) +: 2] = led_mode[i];
      if (reg_addr == ADDR_PWM0 + 5'(i))
        rd_data_p0 = pwm_reg[i];
    end
  end

  // Read port: the mux sees pre-write contents, so read+write to one
  // address returns the old value.
  always_ff @(posedge clk_400K or negedge reset) begin
    if (!reset) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
    end else begin
      reg_rvalid <= reg_read;
      if (reg_read) reg_rdata <= rd_data_p0;
    end
  end

  // Stage p0: counter events
  assign wrap_p0        = !mode_sleep && (pwm_cnt == '1);
  assign tick_p0        = (presc == PS_LAST);
  assign dmblnk_flip_p0 = reg_write && (reg_addr == ADDR_MODE) &&
                          (reg_wdata[MODE_DMBLNK_BIT] != mode_dmblnk);

  always_ff @(posedge clk_400K or negedge reset) begin
    if (!reset) begin
      pwm_cnt   <= '0;
      grp_cnt   <= '0;
      blink_pos <= '0;
      freq_cnt  <= '0;
      presc     <= '0;
    end else if (mode_sleep) begin
      pwm_cnt   <= '0;
      grp_cnt   <= '0;
      blink_pos <= '0;
      freq_cnt  <= '0;
      presc     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (dmblnk_flip_p0) begin
        grp_cnt   <= '0;
        blink_pos <= '0;
        freq_cnt  <= '0;
        presc     <= '0;
      end else begin
        if (wrap_p0) grp_cnt <= grp_cnt + 1'b1;
        if (tick_p0) begin
          presc <= '0;
          // >= rather than == keeps the divider sane if GRPFREQ shrinks mid-count.
          if (freq_cnt >= grpfreq) begin
            freq_cnt  <= '0;
            blink_pos <= blink_pos + 1'b1;
          end else begin
            freq_cnt <= freq_cnt + 1'b1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  assign grp_gate_p0 = mode_dmblnk ? (blink_pos < grppwm) : (grp_cnt < grppwm);
  assign sleep       = mode_sleep;

  // Stage p1: per-LED channels (registered outputs)
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk_400K (clk_400K),
      .reset    (reset),
      .hold     (mode_sleep),
      .wrap     (wrap_p0),
      .duty     (pwm_reg[g][7 -: PWM_BITS]),
      .pwm_cnt  (pwm_cnt),
      .mode     (led_mode[g]),
      .grp_gate (grp_gate_p0),
      .led      (leds[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_array.sv
// Testbench for led_pwm_array (NUM_LEDS=4, PWM_BITS=8, BLINK_PRESCALE=1).
// The reference model tracks the register contents and the time elapsed since
// the counters last restarted; counter-derived quantities come from modular
// arithmetic on that time.
module tb_led_pwm_array;

  localparam int NL     = 4;
  localparam int PB     = 8;
  localparam int BP     = 1;
  localparam int PERIOD = 1 << PB;

  logic          clk_400K = 1'b0;
  logic          reset    = 1'b1;
  logic [4:0]    reg_addr = '0;
  logic [7:0]    reg_wdata = '0;
  logic          reg_write = 1'b0;
  logic          reg_read  = 1'b0;
  logic [7:0]    reg_rdata;
  logic          reg_rvalid;
  logic [NL-1:0] leds;
  logic          sleep;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_400K = ~clk_400K;

  led_pwm_array #(
    .NUM_LEDS       (NL),
    .PWM_BITS       (PB),
    .BLINK_PRESCALE (BP)
  ) dut (
    .clk_400K   (clk_400K),
    .reset      (reset),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_rdata  (reg_rdata),
    .reg_rvalid (reg_rvalid),
    .leds       (leds),
    .sleep      (sleep)
  );

  // ---------------- reference model ----------------
  logic          m_sleep, m_dmblnk;
  logic [7:0]    m_grppwm, m_grpfreq;
  logic [1:0]    m_ledout [NL];
  logic [7:0]    m_pwm    [NL];
  logic [7:0]    m_shadow [NL];
  int            m_t;        // cycles since counters restarted
  logic [NL-1:0] m_leds;
  logic [7:0]    m_rdata;
  logic          m_rvalid;
  int            hi_cnt [8]; // leds[0] on-cycles per PWM period since wake

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sleep = 1'b1; m_dmblnk = 1'b0; m_grppwm = '0; m_grpfreq = '0;
    for (int i = 0; i < NL; i++) begin
      m_ledout[i] = '0; m_pwm[i] = '0; m_shadow[i] = '0;
    end
    m_t = 0; m_leds = '0; m_rdata = '0; m_rvalid = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [4:0] a);
    logic [7:0] v;
    int ai;
    v  = '0;
    ai = int'(a);
    if (ai == 0) v = {2'b00, m_dmblnk, m_sleep, 4'h0};
    else if (ai == 1) v = m_grppwm;
    else if (ai == 2) v = m_grpfreq;
    else if (ai >= 4 && ai <= 7) begin
      for (int i = 0; i < NL; i++)
        if (i / 4 == ai - 4) v[2*(i%4) +: 2] = m_ledout[i];
    end else if (ai >= 16 && ai - 16 < NL) v = m_pwm[ai-16];
    return v;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (ai == 0) begin m_sleep = d[4]; m_dmblnk = d[5]; end
    else if (ai == 1) m_grppwm = d;
    else if (ai == 2) m_grpfreq = d;
    else if (ai >= 4 && ai <= 7) begin
      for (int i = 0; i < NL; i++)
        if (i / 4 == ai - 4) m_ledout[i] = d[2*(i%4) +: 2];
    end else if (ai >= 16 && ai - 16 < NL) m_pwm[ai-16] = d;
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic model_step();
    int cnt, grp, blink;
    logic gate, raw;
    logic [NL-1:0] nl;
    cnt   = m_t % PERIOD;
    grp   = (m_t / PERIOD) % 256;
    blink = (m_t / BP / (int'(m_grpfreq) + 1)) % 256;
    gate  = m_dmblnk ? (blink < int'(m_grppwm)) : (grp < int'(m_grppwm));
    for (int i = 0; i < NL; i++) begin
      raw = cnt < int'(m_shadow[i]);
      case (m_ledout[i])
        2'd0:    nl[i] = 1'b0;
        2'd1:    nl[i] = 1'b1;
        2'd2:    nl[i] = raw;
        default: nl[i] = raw & gate;
      endcase
    end
    m_leds = m_sleep ? '0 : nl;
    if (reg_read) m_rdata = m_read(reg_addr);
    m_rvalid = reg_read;
    for (int i = 0; i < NL; i++) begin
      if (m_sleep) m_shadow[i] = '0;
      else if (cnt == PERIOD - 1) m_shadow[i] = m_pwm[i];
    end
    m_t = m_sleep ? 0 : m_t + 1;
    if (reg_write) m_write(reg_addr, reg_wdata);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    int p;
    @(posedge clk_400K);
    if (!reset) model_reset(); else model_step();
    @(negedge clk_400K);
    check_eq("leds",   leds,       m_leds);
    check_eq("sleep",  sleep,      m_sleep);
    check_eq("rvalid", reg_rvalid, m_rvalid);
    check_eq("rdata",  reg_rdata,  m_rdata);
    if (!m_sleep && m_t >= 1) begin
      p = (m_t - 1) / PERIOD;
      if (p < 8) hi_cnt[p] += int'(leds[0]);
    end
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_write = 1'b1;
    cycle();
    reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [4:0] a);
    reg_addr = a; reg_read = 1'b1;
    cycle();
    reg_read = 1'b0;
  endtask

  task automatic wake(input logic [7:0] mode_val);
    for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    reg_wr(5'h00, mode_val);
  endtask

  task automatic run_until(input int target);
    for (int k = 0; k < 4 * PERIOD && m_t < target; k++) cycle();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    #1 reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;

    // Reset state and first read
    check_eq("rst_leds",  leds,  4'h0);
    check_eq("rst_sleep", sleep, 1'b1);
    reg_rd(5'h00);
    check_eq("rst_mode_rvalid", reg_rvalid, 1'b1);
    check_eq("rst_mode_rdata",  reg_rdata,  8'h10);
    cycle();
    check_eq("rvalid_pulse", reg_rvalid, 1'b0);
    check_eq("rdata_hold",   reg_rdata,  8'h10);

    // 25% duty on LED0, then mid-period duty change
    wake(8'h00);
    reg_wr(5'h10, 8'h40);
    reg_wr(5'h04, 8'h02);
    run_until(2 * PERIOD + 16);
    reg_wr(5'h10, 8'h20);
    run_until(4 * PERIOD + 1);
    check_eq("duty_p0_off",  hi_cnt[0], 0);
    check_eq("duty_p1_64",   hi_cnt[1], 64);
    check_eq("duty_p2_keep", hi_cnt[2], 64);
    check_eq("duty_p3_32",   hi_cnt[3], 32);

    // Fully on, sleep, wake
    reg_wr(5'h04, 8'h55);
    repeat (3) cycle();
    check_eq("on_leds", leds, 4'hF);
    reg_wr(5'h00, 8'h10);
    cycle();
    check_eq("sleep_leds", leds, 4'h0);
    reg_wr(5'h00, 8'h00);
    cycle();
    check_eq("wake_leds", leds, 4'hF);
    repeat (20) cycle();

    // Asynchronous reset mid-pulse
    check_eq("pre_rst_leds", leds, 4'hF);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_leds",   leds,       4'h0);
    check_eq("async_rst_sleep",  sleep,      1'b1);
    check_eq("async_rst_rvalid", reg_rvalid, 1'b0);
    check_eq("async_rst_rdata",  reg_rdata,  8'h00);
    repeat (2) cycle();
    reset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      reg_rd(5'(a));
      check_eq("post_rst_reg", reg_rdata, (a == 0) ? 8'h10 : 8'h00);
    end

    // Blink mode, 50% group gate, near-full duty
    reg_wr(5'h02, 8'h00);
    reg_wr(5'h01, 8'h80);
    reg_wr(5'h10, 8'hFF);
    reg_wr(5'h04, 8'h03);
    wake(8'h20);
    run_until(3 * PERIOD + 1);
    check_eq("blink_p0", hi_cnt[0], 0);
    check_eq("blink_p1", hi_cnt[1], 128);
    check_eq("blink_p2", hi_cnt[2], 128);

    // Read and write of the same register in one cycle
    reg_addr = 5'h10; reg_wdata = 8'h33; reg_write = 1'b1; reg_read = 1'b1;
    cycle();
    reg_write = 1'b0; reg_read = 1'b0;
    check_eq("rw_same_old", reg_rdata, 8'hFF);
    reg_rd(5'h10);
    check_eq("rw_same_new", reg_rdata, 8'h33);

    // Randomized segments
    for (int s = 0; s < 6; s++) begin
      reg_wr(5'h00, 8'h10);
      reg_wr(5'h02, 8'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) reg_wr(5'h01, 8'($urandom_range(0, 4)));
      else reg_wr(5'h01, 8'($urandom));
      wake(($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00);
      for (int k = 0; k < 700; k++) begin
        int r;
        logic [4:0] a;
        r = int'($urandom_range(0, 9));
        a = 5'($urandom);
        reg_write = (r < 3) || (r == 9);
        reg_read  = (r >= 3 && r < 6) || (r == 9);
        // MODE and GRPFREQ change only while asleep
        if (reg_write && (a == 5'h00 || a == 5'h02)) a = 5'h10 + 5'($urandom_range(0, NL - 1));
        reg_addr  = a;
        reg_wdata = 8'($urandom);
        cycle();
        reg_write = 1'b0; reg_read = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
